// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute sequencer for the accumulator computer, with MRDY wait states and bus watchdog.
// Build option: define SEQ_ILLEGAL_TRAP_EN to halt and flag ILLEGAL on undefined opcodes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_RST    | outputs idle; one extra cycle after AR_N release
// S_FETCH  | PC on address bus, read opcode; IRL/PCI on MRDY
// S_DECODE | branch on sampled IOP/ZF/NF, latch execute kind
// S_EXEC   | memory access or PC load via IR address field
// S_HALT   | stopped until AR_N; HALTED=1
module ctrl_sequencer #(
  parameter int OPW = 8,
  parameter int TMO = 16
) (
  input  logic           CLK,
  input  logic           AR_N,
  input  logic [OPW-1:0] IOP,
  input  logic           ZF,
  input  logic           NF,
  input  logic           MRDY,
  output logic           IRL,
  output logic           IRA,
  output logic           PCA,
  output logic           PCI,
  output logic           PCL,
  output logic           MRD,
  output logic           MWR,
  output logic           ACL,
  output logic           ACE,
  output logic [1:0]     ALUOP,
  output logic           HALTED,
  output logic           BUSERR,
  output logic           ILLEGAL
);

  typedef enum logic [2:0] {S_RST, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;
  typedef enum logic [2:0] {K_LDA, K_ADD, K_SUB, K_AND, K_STA, K_JMP} kind_t;

  localparam logic [OPW-1:0] OP_NOP = OPW'(8'h00);
  localparam logic [OPW-1:0] OP_LDA = OPW'(8'h01);
  localparam logic [OPW-1:0] OP_STA = OPW'(8'h02);
  localparam logic [OPW-1:0] OP_ADD = OPW'(8'h03);
  localparam logic [OPW-1:0] OP_SUB = OPW'(8'h04);
  localparam logic [OPW-1:0] OP_AND = OPW'(8'h05);
  localparam logic [OPW-1:0] OP_JMP = OPW'(8'h06);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(8'h07);
  localparam logic [OPW-1:0] OP_JN  = OPW'(8'h08);
  localparam logic [OPW-1:0] OP_HLT = OPW'(8'hFF);

  localparam int CW = (TMO > 1) ? $clog2(TMO + 1) : 1;
  localparam logic [CW-1:0] TMO_LD = CW'(TMO);

  state_t        state;
  kind_t         kind;
  kind_t         dec_kind;
  logic          rst_seen;
  logic [CW-1:0] wait_left;
  logic          go_exec, go_halt, undef;
  logic          mem_op, waiting, timeout;

  always_comb begin
    go_exec  = 1'b0;
    go_halt  = 1'b0;
    undef    = 1'b0;
    dec_kind = K_LDA;
    case (IOP)
      OP_NOP: ;
      OP_LDA: begin go_exec = 1'b1; dec_kind = K_LDA; end
      OP_ADD: begin go_exec = 1'b1; dec_kind = K_ADD; end
      OP_SUB: begin go_exec = 1'b1; dec_kind = K_SUB; end
      OP_AND: begin go_exec = 1'b1; dec_kind = K_AND; end
      OP_STA: begin go_exec = 1'b1; dec_kind = K_STA; end
      OP_JMP: begin go_exec = 1'b1; dec_kind = K_JMP; end
      OP_JZ:  begin go_exec = ZF;   dec_kind = K_JMP; end
      OP_JN:  begin go_exec = NF;   dec_kind = K_JMP; end
      OP_HLT: go_halt = 1'b1;
      default: undef = 1'b1;
    endcase
  end

  // Watchdog is a down-counter reloaded on any progress; terminal count 1 means TMO waits seen.
  assign mem_op  = (kind != K_JMP);
  assign waiting = !MRDY && ((state == S_FETCH) || ((state == S_EXEC) && mem_op));
  assign timeout = (TMO != 0) && waiting && (wait_left == CW'(1));

`ifdef SEQ_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign ILLEGAL = illegal_q;
`else
  assign ILLEGAL = 1'b0;
`endif

  always_ff @(posedge CLK or negedge AR_N) begin
    if (!AR_N) begin
      state     <= S_RST;
      kind      <= K_LDA;
      rst_seen  <= 1'b0;
      wait_left <= TMO_LD;
      BUSERR    <= 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      wait_left <= TMO_LD;
      if ((TMO != 0) && waiting && !timeout)
        wait_left <= wait_left - CW'(1);
      case (state)
        S_RST: begin
          rst_seen <= 1'b1;
          if (rst_seen) state <= S_FETCH;
        end
        S_FETCH: begin
          if (timeout) begin
            state  <= S_HALT;
            BUSERR <= 1'b1;
          end else if (MRDY) begin
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          kind <= dec_kind;
          if (go_halt) begin
            state <= S_HALT;
          end else if (go_exec) begin
            state <= S_EXEC;
          end else if (undef) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
            state     <= S_HALT;
            illegal_q <= 1'b1;
`else
            state <= S_FETCH;
`endif
          end else begin
            state <= S_FETCH;
          end
        end
        S_EXEC: begin
          if (timeout) begin
            state  <= S_HALT;
            BUSERR <= 1'b1;
          end else if (!mem_op || MRDY) begin
            state <= S_FETCH;
          end
        end
        S_HALT: ;
        default: state <= S_RST;
      endcase
    end
  end

  always_comb begin
    IRL   = 1'b0;
    IRA   = 1'b0;
    PCA   = 1'b0;
    PCI   = 1'b0;
    PCL   = 1'b0;
    MRD   = 1'b0;
    MWR   = 1'b0;
    ACL   = 1'b0;
    ACE   = 1'b0;
    ALUOP = 2'b00;
    case (state)
      S_FETCH: begin
        PCA = 1'b1;
        MRD = 1'b1;
        IRL = MRDY;
        PCI = MRDY;
      end
      S_EXEC: begin
        IRA = 1'b1;
        case (kind)
          K_JMP: PCL = 1'b1;
          K_STA: begin
            MWR = 1'b1;
            ACE = 1'b1;
          end
          default: begin
            MRD = 1'b1;
            ACL = MRDY;
            case (kind)
              K_ADD:   ALUOP = 2'b01;
              K_SUB:   ALUOP = 2'b10;
              K_AND:   ALUOP = 2'b11;
              default: ALUOP = 2'b00;
            endcase
          end
        endcase
      end
      default: ;
    endcase
  end

  assign HALTED = (state == S_HALT);

endmodule
